// File: rtl/if_id_stage.sv
// Fetch PC plus IF/ID register; the instruction at pc=A appears on ifid_instr one edge later.
// Backpressure: pc_write/ifid_write hold PC and IF/ID independently; branch_taken flushes and beats both.
module if_id_stage #(
  parameter int PC_W     = 16,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0,
  parameter int NOP      = 0,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_write,
  input  logic               ifid_write,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc1,
  output logic               ifid_valid,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic [PC_W-1:0] pcPlus1;
  logic            cntSat;

  assign imem_addr = pc;
  assign pcPlus1   = pc + PC_W'(1);
  assign cntSat    = &stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= PC_W'(RESET_PC);
      ifid_instr <= INSTR_W'(NOP);
      ifid_pc1   <= '0;
      ifid_valid <= 1'b0;
      stall_cnt  <= '0;
    end else if (branch_taken) begin
      // Flush: the wrong-path fetch becomes a bubble; ifid_pc1 is left as-is.
      pc         <= branch_target;
      ifid_instr <= INSTR_W'(NOP);
      ifid_valid <= 1'b0;
    end else begin
      if (pc_write) begin
        pc <= pcPlus1;
      end else if (!cntSat) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (ifid_write) begin
        ifid_instr <= imem_rdata;
        ifid_pc1   <= pcPlus1;
        ifid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage; instruction memory modelled as imem[n] = 16'h1000 + n.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcWrite, ifidWrite, branchTaken;
  logic [15:0] branchTarget;
  logic [15:0] imemAddr, imemRdata, pc, ifidInstr, ifidPc1, stallCnt;
  logic        ifidValid;
  logic [15:0] imemAddrS, imemRdataS, pcS, ifidInstrS, ifidPc1S;
  logic        ifidValidS;
  logic [1:0]  stallCntS;

  int vecCnt  = 0;
  int missCnt = 0;

  always #5 clk = ~clk;

  assign imemRdata  = 16'h1000 + imemAddr;
  assign imemRdataS = 16'h1000 + imemAddrS;

  if_id_stage dut (
    .clk(clk), .rst(rst), .pc_write(pcWrite), .ifid_write(ifidWrite),
    .branch_taken(branchTaken), .branch_target(branchTarget),
    .imem_addr(imemAddr), .imem_rdata(imemRdata), .pc(pc),
    .ifid_instr(ifidInstr), .ifid_pc1(ifidPc1), .ifid_valid(ifidValid),
    .stall_cnt(stallCnt)
  );

  if_id_stage #(.CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .pc_write(pcWrite), .ifid_write(ifidWrite),
    .branch_taken(branchTaken), .branch_target(branchTarget),
    .imem_addr(imemAddrS), .imem_rdata(imemRdataS), .pc(pcS),
    .ifid_instr(ifidInstrS), .ifid_pc1(ifidPc1S), .ifid_valid(ifidValidS),
    .stall_cnt(stallCntS)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      missCnt++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkIfId(input string tag, input logic [15:0] ePc, input logic [15:0] eInstr,
                         input logic [15:0] ePc1, input logic eValid);
    chk({tag, ".pc"},    32'(pc),        32'(ePc));
    chk({tag, ".addr"},  32'(imemAddr),  32'(ePc));
    chk({tag, ".instr"}, 32'(ifidInstr), 32'(eInstr));
    chk({tag, ".pc1"},   32'(ifidPc1),   32'(ePc1));
    chk({tag, ".valid"}, 32'(ifidValid), 32'(eValid));
  endtask

  initial begin
    rst = 1'b1; pcWrite = 1'b1; ifidWrite = 1'b1; branchTaken = 1'b0; branchTarget = '0;
    step(); step();
    chkIfId("rst", 16'h0, 16'h0, 16'h0, 1'b0);
    chk("rst.cnt", 32'(stallCnt), 32'd0);
    rst = 1'b0;

    // Straight-line fetch
    for (int k = 1; k <= 5; k++) begin
      step();
      chkIfId($sformatf("line%0d", k), 16'(k), 16'h1000 + 16'(k - 1), 16'(k), 1'b1);
    end

    // Load-use stall at pc=5
    pcWrite = 1'b0; ifidWrite = 1'b0;
    step(); step();
    chkIfId("stall", 16'h5, 16'h1004, 16'h5, 1'b1);
    chk("stall.cnt", 32'(stallCnt), 32'd2);
    chk("stall.cntS", 32'(stallCntS), 32'd2);
    pcWrite = 1'b1; ifidWrite = 1'b1;
    step();
    chkIfId("unstall", 16'h6, 16'h1005, 16'h6, 1'b1);
    step(); step();
    chkIfId("pc8", 16'h8, 16'h1007, 16'h8, 1'b1);

    // Split enables: PC advances, IF/ID holds
    ifidWrite = 1'b0;
    step();
    chkIfId("split", 16'h9, 16'h1007, 16'h8, 1'b1);
    chk("split.cnt", 32'(stallCnt), 32'd2);

    // Branch during stall flushes and redirects
    pcWrite = 1'b0; branchTaken = 1'b1; branchTarget = 16'h0040;
    step();
    chkIfId("br", 16'h40, 16'h0, 16'h8, 1'b0);
    chk("br.cnt", 32'(stallCnt), 32'd2);
    branchTaken = 1'b0; pcWrite = 1'b1; ifidWrite = 1'b1;
    step();
    chkIfId("brtgt", 16'h41, 16'h1040, 16'h41, 1'b1);

    // PC wrap
    branchTaken = 1'b1; branchTarget = 16'hFFFF;
    step();
    chk("wrap.pre", 32'(pc), 32'hFFFF);
    branchTaken = 1'b0;
    step();
    chkIfId("wrap", 16'h0, 16'h0FFF, 16'h0, 1'b1);

    // Saturation: 5 more stalls -> wide counter 7, 2-bit counter pinned at 3
    pcWrite = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("sat.cnt", 32'(stallCnt), 32'd7);
    chk("sat.cntS", 32'(stallCntS), 32'd3);
    chk("sat.pc", 32'(pc), 32'h0);

    // Asynchronous reset mid-cycle
    pcWrite = 1'b1;
    step(); step();
    chk("pre.pc", 32'(pc), 32'h2);
    #2 rst = 1'b1;
    #1;
    chkIfId("arst", 16'h0, 16'h0, 16'h0, 1'b0);
    chk("arst.cnt", 32'(stallCnt), 32'd0);
    chk("arst.cntS", 32'(stallCntS), 32'd0);
    step();
    rst = 1'b0;
    step();
    chkIfId("post", 16'h1, 16'h1000, 16'h1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
